// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, defaults and the bubble encoding for the ID-stage hazard scoreboard
package hazard_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS = 32;
  localparam int LOAD_DELAY = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/sb_entry.sv
// sb_entry: one register's load countdown and long-op pending flag
module sb_entry
  import hazard_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int LOAD_DELAY = hazard_pkg::LOAD_DELAY
) (
  input  logic clk,
  input  logic rst,
  input  logic set_load,
  input  logic set_alu,
  input  logic set_long,
  input  logic clr_long,
  output logic lng,
  output logic pending
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    cnt <= rst ? '0 : set_load ? CNT_W'(LOAD_DELAY) : set_alu ? '0 : cnt - CNT_W'(cnt != '0);
    lng <= rst ? 1'b0 : set_long ? 1'b1 : clr_long ? 1'b0 : lng;
  end
  assign pending = (cnt != '0) | lng;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall/bubble control for in-flight load and long-latency writes
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = hazard_pkg::NUM_REGS,
  parameter int LOAD_DELAY = hazard_pkg::LOAD_DELAY,
  parameter int CNT_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic [REG_IDX_W-1:0] id_rd_i,
  input  logic                 id_regwrite_i,
  input  logic                 id_is_load_i,
  input  logic                 id_is_long_i,
  input  logic                 long_done_i,
  input  logic [REG_IDX_W-1:0] long_rd_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic                 bubble_o,
  output logic                 issue_o,
  output logic                 long_busy_o,
  output logic [NUM_REGS-1:0]  pending_o
);
  logic [NUM_REGS-1:0] lng;
  logic long_busy, haz, wr;
  assign pending_o[0] = 1'b0;
  assign lng[0] = 1'b0;
  assign haz = (id_use_rs1_i & pending_o[id_rs1_i]) | (id_use_rs2_i & pending_o[id_rs2_i])
             | (id_regwrite_i & (id_rd_i != '0) & lng[id_rd_i]) | (id_is_long_i & long_busy);
  assign stall_o = id_valid_i & haz & ~flush_i;
  assign bubble_o = flush_i | stall_o;
  assign issue_o = id_valid_i & ~haz & ~flush_i;
  assign long_busy_o = long_busy;
  assign wr = issue_o & id_regwrite_i & (id_rd_i != '0);
  always_ff @(posedge clk_i) begin
    long_busy <= rst_i ? 1'b0 : (wr & id_is_long_i) ? 1'b1 : long_done_i ? 1'b0 : long_busy;
  end
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    logic hit;
    assign hit = wr & (id_rd_i == REG_IDX_W'(r));
    sb_entry #(.CNT_W(CNT_W), .LOAD_DELAY(LOAD_DELAY)) u_ent (
      .clk(clk_i),
      .rst(rst_i),
      .set_load(hit & id_is_load_i),
      .set_alu(hit & ~id_is_load_i & ~id_is_long_i),
      .set_long(hit & id_is_long_i),
      .clr_long(long_done_i & (long_rd_i == REG_IDX_W'(r))),
      .lng(lng[r]),
      .pending(pending_o[r])
    );
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Issue-side hazard controller in the decode (ID) stage of the 5-stage pipeline.
- It records which architectural registers have writes still in flight from loads and from the multi-cycle long-latency unit.
- It stalls the decoding instruction until its sources are forwardable, inserts bubbles into ID/EX, and releases entries on countdown or on long-unit completion.
- It complements the EX-stage operand forwarding: ALU results need no stall; loads and long ops do.

## Interface

Parameters:
- NUM_REGS, 32, architectural register count; x0 is never tracked.
- LOAD_DELAY, 1, bubbles required between a load and a dependent instruction.
- CNT_W, 2, per-register countdown width; must hold LOAD_DELAY.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- id_valid_i  in  1  ID holds a valid instruction.
- id_rs1_i / id_rs2_i  in  5 each  source register indices.
- id_use_rs1_i / id_use_rs2_i  in  1 each  the instruction reads that source.
- id_rd_i  in  5  destination index.
- id_regwrite_i  in  1  the instruction writes rd.
- id_is_load_i  in  1  the instruction is a load.
- id_is_long_i  in  1  the instruction goes to the long-latency unit.
- long_done_i  in  1  the long unit writes back this cycle.
- long_rd_i  in  5  destination of the completing long op.
- flush_i  in  1  branch/jump flush of the ID instruction.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  load a NOP into ID/EX.
- issue_o  out  1  the ID instruction advances this cycle.
- long_busy_o  out  1  a long op is outstanding.
- pending_o  out  NUM_REGS  per-register pending vector, for debug and the bench.

## Operation

- State per register r, for r = 1..31:
  - cnt[r], CNT_W bits: load countdown.
  - lng[r], 1 bit: long op pending.
  - pending_o[r] = (cnt[r] != 0) | lng[r].
  - Bit 0 is constant 0.
- Global state: long_busy. Only one long op is outstanding at a time.
- Hazard term haz, computed only from registered state:
  - use_rs1 and pending[rs1], or
  - use_rs2 and pending[rs2], or
  - regwrite and rd != 0 and lng[rd] (WAW against an out-of-order long writeback), or
  - is_long and long_busy.
- stall_o = id_valid_i & haz & ~flush_i. Flush dominates.
- bubble_o = flush_i | stall_o.
- issue_o = id_valid_i & ~haz & ~flush_i.
- On issue with regwrite and rd != 0:
  - load: cnt[rd] <= LOAD_DELAY.
  - long: lng[rd] <= 1 and long_busy <= 1. is_load and is_long are mutually exclusive.
  - otherwise (ALU op): cnt[rd] <= 0. In-order ALU writeback supersedes an older load.
- Every cycle, each nonzero cnt not being written by an issue decrements by 1.
- long_done_i: lng[long_rd_i] <= 0 and long_busy <= 0.
- Simultaneous events:
  - long_done_i in the same cycle as a dependent ID instruction: still stalls that cycle; it issues the next cycle.
  - long_done_i in the same cycle as an issuing long op: cannot happen, because long_busy forces a stall.
  - Issue and countdown on the same register: the issue value wins.
- flush_i does not clear scoreboard state, because older instructions remain in flight.
- rst_i clears all cnt, lng and long_busy.
- A reset asserted mid-stall deasserts stall_o in the cycle after the reset edge.

## Timing

- Outputs are combinational from registered state plus the ID inputs. No output register.
- Reset values: pending_o = 0, long_busy_o = 0. With id_valid_i = 0 and flush_i = 0: stall_o = 0, bubble_o = 0, issue_o = 0.
- Load issued at edge t: a dependent instruction in ID during t+1 stalls exactly LOAD_DELAY cycles, then issues in cycle t+1+LOAD_DELAY. The forwarding unit supplies the value from MEM/WB.
- Long op: dependents stall until the cycle after long_done_i. Minimum release latency is 1 cycle from long_done_i.
- ALU producers never cause a stall.

## Structure

- Shared package hazard_pkg holds:
  - REG_IDX_W = 5, NUM_REGS, LOAD_DELAY.
  - The NOP encoding used for bubbles.
- One natural sub-module: sb_entry, a single-register cnt/lng cell with set-load, set-long, clear-long and decrement.
  - hazard_scoreboard instantiates 31 entries through generate.
  - The top level holds the hazard mux and long_busy.

## Test plan

- Load x5, then add x6,x5,x1 back-to-back:
  - stall_o = 1 for exactly 1 cycle.
  - bubble_o = 1 in that cycle.
  - issue_o = 1 in the next cycle.
  - pending_o[5] is 1 for one cycle.
- add x5, then sub x7,x5,x5 back-to-back: stall_o never asserts.
- Long op writing x9, then dependent or x3,x9,x0, with long_done_i (long_rd_i = 9) pulsed 6 cycles later:
  - stall_o holds through the done cycle.
  - issue_o = 1 the cycle after.
  - long_busy_o is 0 from then on.
- Two long ops back-to-back, independent registers: the second stalls until the cycle after long_done_i. Also add x9 issued while x9 is long-pending: stalls (WAW).
- Load writing x0, then an instruction reading x0: no stall; pending_o = 0.
- Load x5, then flush_i asserted with a dependent instruction in ID: stall_o = 0, bubble_o = 1, issue_o = 0, pending_o[5] still counts down. Assert rst_i during a long stall: pending_o = 0 and stall_o = 0 the cycle after the reset edge.
